// File: rtl/adbg_lint_master_pkg.sv
// Shared debug package for the lint bus master.
// Holds the master FSM state encoding, the access-size constants and the
// byte-enable decode used for lane steering (write BE and read data mask).
package adbg_lint_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  // Access sizes in bytes
  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  // ((1 << size) - 1) << off, for the four legal sizes; anything else gives 0.
  // Written as a table so size 8 does not need a 9-bit intermediate.
  function automatic logic [7:0] be_from_size(input logic [3:0] size,
                                              input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      SZ_D:    base = 8'hFF;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/adbg_lint_master.sv
// Single-outstanding lint bus master for the advanced debug interface.
// Accepts one debug access command, checks size/alignment, steers the data
// onto the correct byte lanes, runs the lint req/gnt + r_valid handshake
// with a timeout, and returns LSB-aligned read data plus an error flag.
//
// Ports:
//   clk_i, rst_i              system clock, synchronous active-high reset
//   cmd_*                     command channel (valid/ready handshake)
//   rsp_*                     response channel (valid held until ready)
//   lint_*_o / lint_*_i       lint bus request and response signals
module adbg_lint_master
  import adbg_lint_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned AUX_WIDTH  = 6,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic                    cmd_rd_wrn_i,
  input  logic [3:0]              cmd_size_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    lint_req_o,
  output logic [ADDR_WIDTH-1:0]   lint_add_o,
  output logic                    lint_wen_o,
  output logic [DATA_WIDTH-1:0]   lint_wdata_o,
  output logic [DATA_WIDTH/8-1:0] lint_be_o,
  output logic [AUX_WIDTH-1:0]    lint_aux_o,
  input  logic                    lint_gnt_i,
  input  logic                    lint_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   lint_r_rdata_i,
  input  logic                    lint_r_opc_i
);

  localparam int unsigned BE_W    = DATA_WIDTH / 8;
  localparam int unsigned OFS     = $clog2(BE_W);
  localparam logic [3:0]  BE_W_SZ = 4'(BE_W);
  // Timer value seen in the last cycle before the abort edge
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [7:0]              timer_q, timer_d;
  logic [OFS-1:0]          off_q, off_d;
  logic [3:0]              size_q, size_d;
  logic                    lint_req_q, lint_req_d;
  logic [ADDR_WIDTH-1:0]   lint_add_q, lint_add_d;
  logic                    lint_wen_q, lint_wen_d;
  logic [DATA_WIDTH-1:0]   lint_wdata_q, lint_wdata_d;
  logic [BE_W-1:0]         lint_be_q, lint_be_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [OFS-1:0]          cmd_off_s;
  logic [3:0]              size_m1_s;
  logic                    cmd_legal_s;
  logic [7:0]              cmd_be_s;
  logic [7:0]              keep_s;
  logic [DATA_WIDTH-1:0]   rd_mask_s;
  logic [DATA_WIDTH-1:0]   rd_steer_s;

  // Command legality check and write-side lane steering
  always_comb begin
    cmd_off_s   = cmd_addr_i[OFS-1:0];
    size_m1_s   = cmd_size_i - 4'd1;
    // Sizes are powers of two, so "offset multiple of size" is a mask test
    cmd_legal_s = ((cmd_size_i == SZ_B) || (cmd_size_i == SZ_H) ||
                   (cmd_size_i == SZ_W) || (cmd_size_i == SZ_D)) &&
                  (cmd_size_i <= BE_W_SZ) &&
                  ((cmd_off_s & size_m1_s[OFS-1:0]) == '0);
    cmd_be_s    = be_from_size(cmd_size_i, 3'(cmd_off_s));
  end

  // Read-side steering: shift the addressed lanes down and zero above size
  always_comb begin
    keep_s    = be_from_size(size_q, 3'd0);
    rd_mask_s = '0;
    for (int i = 0; i < int'(BE_W); i++) begin
      rd_mask_s[8*i +: 8] = {8{keep_s[i]}};
    end
    rd_steer_s = (lint_r_rdata_i >> {off_q, 3'b000}) & rd_mask_s;
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    off_d        = off_q;
    size_d       = size_q;
    lint_req_d   = lint_req_q;
    lint_add_d   = lint_add_q;
    lint_wen_d   = lint_wen_q;
    lint_wdata_d = lint_wdata_q;
    lint_be_d    = lint_be_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_legal_s) begin
            state_d      = ST_REQ;
            timer_d      = 8'd0;
            off_d        = cmd_off_s;
            size_d       = cmd_size_i;
            lint_req_d   = 1'b1;
            lint_add_d   = {cmd_addr_i[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
            lint_wen_d   = cmd_rd_wrn_i;
            lint_wdata_d = cmd_wdata_i << {cmd_off_s, 3'b000};
            lint_be_d    = cmd_be_s[BE_W-1:0];
          end else begin
            // Illegal: answer straight away, never touch the bus
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (lint_gnt_i && lint_r_valid_i) begin
          state_d     = ST_RESP;
          lint_req_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rd_steer_s;
          rsp_err_d   = lint_r_opc_i;
        end else if (timer_q == TO_LAST) begin
          state_d     = ST_RESP;
          lint_req_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else if (lint_gnt_i) begin
          state_d    = ST_WAIT_RSP;
          lint_req_d = 1'b0;
          timer_d    = timer_q + 8'd1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      ST_WAIT_RSP: begin
        if (lint_r_valid_i) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rd_steer_s;
          rsp_err_d   = lint_r_opc_i;
        end else if (timer_q == TO_LAST) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      timer_q      <= 8'd0;
      off_q        <= '0;
      size_q       <= 4'd0;
      lint_req_q   <= 1'b0;
      lint_add_q   <= '0;
      lint_wen_q   <= 1'b0;
      lint_wdata_q <= '0;
      lint_be_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      off_q        <= off_d;
      size_q       <= size_d;
      lint_req_q   <= lint_req_d;
      lint_add_q   <= lint_add_d;
      lint_wen_q   <= lint_wen_d;
      lint_wdata_q <= lint_wdata_d;
      lint_be_q    <= lint_be_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Ready is held off while reset is applied so nothing is accepted then
  assign cmd_ready_o  = (state_q == ST_IDLE) && !rst_i;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_err_o    = rsp_err_q;
  assign lint_req_o   = lint_req_q;
  assign lint_add_o   = lint_add_q;
  assign lint_wen_o   = lint_wen_q;
  assign lint_wdata_o = lint_wdata_q;
  assign lint_be_o    = lint_be_q;
  assign lint_aux_o   = '0;

endmodule

// File: tb/tb_adbg_lint_master.sv
// Self-checking bench for adbg_lint_master (64-bit data, 32-bit address).
module tb_adbg_lint_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = 32'd0;
  logic [63:0] cmd_wdata = 64'd0;
  logic        cmd_rd_wrn = 1'b0;
  logic [3:0]  cmd_size = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        lint_req;
  logic [31:0] lint_add;
  logic        lint_wen;
  logic [63:0] lint_wdata;
  logic [7:0]  lint_be;
  logic [5:0]  lint_aux;
  logic        lint_gnt = 1'b0;
  logic        lint_r_valid = 1'b0;
  logic [63:0] lint_r_rdata = 64'd0;
  logic        lint_r_opc = 1'b0;

  int checks = 0;
  int errors = 0;

  adbg_lint_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .AUX_WIDTH(6), .TIMEOUT(255)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
    .cmd_wdata_i(cmd_wdata), .cmd_rd_wrn_i(cmd_rd_wrn), .cmd_size_i(cmd_size),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .lint_req_o(lint_req), .lint_add_o(lint_add), .lint_wen_o(lint_wen),
    .lint_wdata_o(lint_wdata), .lint_be_o(lint_be), .lint_aux_o(lint_aux),
    .lint_gnt_i(lint_gnt), .lint_r_valid_i(lint_r_valid),
    .lint_r_rdata_i(lint_r_rdata), .lint_r_opc_i(lint_r_opc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  size;
    logic [63:0] wdata;
    logic        rd;
    logic [63:0] bus;
    logic        opc;
    int          gnt_dly;   // cycles of gnt=0 before the grant cycle
    int          rv_dly;    // 0: r_valid with gnt, n: n cycles after gnt
    logic        exp_legal;
    logic [31:0] exp_add;
    logic [7:0]  exp_be;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: expectations straight from the addressing rules, byte by byte
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int unsigned off = v.addr % 8;
    int unsigned sz = v.size;
    r.exp_legal = (sz == 1 || sz == 2 || sz == 4 || sz == 8);
    if (r.exp_legal) r.exp_legal = ((off % sz) == 0);
    r.exp_add   = v.addr - off;
    r.exp_be    = 8'(((1 << sz) - 1) << off);
    r.exp_wdata = v.wdata << (8 * off);
    r.exp_rdata = 64'd0;
    if (r.exp_legal) begin
      for (int i = 0; i < int'(sz); i++) r.exp_rdata[8*i +: 8] = v.bus[8*(int'(off)+i) +: 8];
    end
    r.exp_err = !r.exp_legal || v.opc;
    return r;
  endfunction

  task automatic do_txn(input vec_t v, input string tag);
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_size = v.size;
    cmd_wdata = v.wdata; cmd_rd_wrn = v.rd; rsp_ready = 1'b0;
    check({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    if (!v.exp_legal) begin
      check({tag, " ill_req"}, 64'(lint_req), 64'd0);
    end else begin
      check({tag, " req"}, 64'(lint_req), 64'd1);
      check({tag, " add"}, 64'(lint_add), 64'(v.exp_add));
      check({tag, " be"}, 64'(lint_be), 64'(v.exp_be));
      check({tag, " wdata"}, lint_wdata, v.exp_wdata);
      check({tag, " wen"}, 64'(lint_wen), 64'(v.rd));
      check({tag, " aux"}, 64'(lint_aux), 64'd0);
      for (int i = 0; i < v.gnt_dly; i++) tick();
      check({tag, " req_held"}, 64'(lint_req), 64'd1);
      lint_gnt = 1'b1;
      if (v.rv_dly == 0) begin
        lint_r_valid = 1'b1; lint_r_rdata = v.bus; lint_r_opc = v.opc;
      end
      tick();
      lint_gnt = 1'b0; lint_r_valid = 1'b0;
      if (v.rv_dly > 0) begin
        check({tag, " req_drop"}, 64'(lint_req), 64'd0);
        for (int i = 1; i < v.rv_dly; i++) tick();
        check({tag, " early_rsp"}, 64'(rsp_valid), 64'd0);
        lint_r_valid = 1'b1; lint_r_rdata = v.bus; lint_r_opc = v.opc;
        tick();
        lint_r_valid = 1'b0;
      end
    end
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, " rdata"}, rsp_rdata, v.exp_rdata);
    check({tag, " err"}, 64'(rsp_err), 64'(v.exp_err));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, " rsp_done"}, 64'(rsp_valid), 64'd0);
    check({tag, " ready_back"}, 64'(cmd_ready), 64'd1);
    if (!v.exp_legal) check({tag, " ill_req_end"}, 64'(lint_req), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_v;
    int req_cnt;
    logic [63:0] held;
    vec_t v;

    // addr, size, wdata, rd, bus, opc, gnt_dly, rv_dly, legal, add, be, wdata, rdata, err
    tbl[0]  = '{32'h1000_0004, 4'd4, 64'hDEAD_BEEF, 1'b0, 64'h0, 1'b0, 0, 1,
                1'b1, 32'h1000_0000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0, 1'b0};
    tbl[1]  = '{32'h1000_0003, 4'd1, 64'h55, 1'b1, 64'h0000_0000_AB00_0000, 1'b0, 0, 1,
                1'b1, 32'h1000_0000, 8'h08, 64'h5500_0000, 64'hAB, 1'b0};
    tbl[2]  = '{32'h1000_0003, 4'd1, 64'h55, 1'b1, 64'h0000_0000_AB00_0000, 1'b1, 0, 1,
                1'b1, 32'h1000_0000, 8'h08, 64'h5500_0000, 64'hAB, 1'b1};
    tbl[3]  = '{32'h0000_1000, 4'd3, 64'h0, 1'b1, 64'h0, 1'b0, 0, 1,
                1'b0, 32'h0, 8'h00, 64'h0, 64'h0, 1'b1};
    tbl[4]  = '{32'h0000_0002, 4'd4, 64'h0, 1'b0, 64'h0, 1'b0, 0, 1,
                1'b0, 32'h0, 8'h00, 64'h0, 64'h0, 1'b1};
    tbl[5]  = '{32'h0000_0020, 4'd8, 64'h1111_2222_3333_4444, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 2,
                1'b1, 32'h20, 8'hFF, 64'h1111_2222_3333_4444, 64'h0123_4567_89AB_CDEF, 1'b0};
    tbl[6]  = '{32'h0000_0106, 4'd2, 64'h0, 1'b1, 64'hBEEF_0000_0000_0000, 1'b0, 1, 0,
                1'b1, 32'h100, 8'hC0, 64'h0, 64'hBEEF, 1'b0};
    tbl[7]  = '{32'h0000_0008, 4'd0, 64'h0, 1'b1, 64'h0, 1'b0, 0, 1,
                1'b0, 32'h0, 8'h00, 64'h0, 64'h0, 1'b1};
    tbl[8]  = '{32'h0000_0000, 4'd15, 64'h0, 1'b1, 64'h0, 1'b0, 0, 1,
                1'b0, 32'h0, 8'h00, 64'h0, 64'h0, 1'b1};
    tbl[9]  = '{32'h0000_0005, 4'd2, 64'h0, 1'b1, 64'h0, 1'b0, 0, 1,
                1'b0, 32'h0, 8'h00, 64'h0, 64'h0, 1'b1};
    tbl[10] = '{32'h0000_0002, 4'd2, 64'hFFFF_FFFF_FFFF_1234, 1'b0, 64'hCAFE_0000, 1'b0, 2, 1,
                1'b1, 32'h0, 8'h0C, 64'hFFFF_FFFF_1234_0000, 64'hCAFE, 1'b0};
    tbl[11] = '{32'hFFFF_FFF8, 4'd4, 64'hA5A5_A5A5, 1'b0, 64'h7777_6666_5555_4444, 1'b1, 0, 0,
                1'b1, 32'hFFFF_FFF8, 8'h0F, 64'hA5A5_A5A5, 64'h5555_4444, 1'b1};
    tbl[12] = '{32'h0000_0004, 4'd8, 64'h0, 1'b1, 64'h0, 1'b0, 0, 1,
                1'b0, 32'h0, 8'h00, 64'h0, 64'h0, 1'b1};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    check("rst lint_req", 64'(lint_req), 64'd0);
    check("rst rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst rsp_err", 64'(rsp_err), 64'd0);
    check("rst rsp_rdata", rsp_rdata, 64'd0);
    check("rst lint_be", 64'(lint_be), 64'd0);
    check("rst lint_add", 64'(lint_add), 64'd0);
    check("rst lint_wdata", lint_wdata, 64'd0);
    check("rst lint_wen", 64'(lint_wen), 64'd0);
    check("rst lint_aux", 64'(lint_aux), 64'd0);
    rst = 1'b0;
    #1;
    check("rst cmd_ready", 64'(cmd_ready), 64'd1);

    // Directed vectors
    for (int i = 0; i < 13; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

    // Timeout: grant never comes
    cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_size = 4'd4; cmd_rd_wrn = 1'b1;
    tick();
    cmd_valid = 1'b0;
    req_cnt = lint_req ? 1 : 0;
    first_v = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (lint_req) req_cnt++;
      if (rsp_valid && first_v == 0) first_v = i;
    end
    check("to rsp_edge", 64'(first_v), 64'd255);
    check("to req_cycles", 64'(req_cnt), 64'd255);
    check("to err", 64'(rsp_err), 64'd1);
    check("to rdata", rsp_rdata, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    lint_r_valid = 1'b1; lint_r_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    lint_r_valid = 1'b0;
    tick(); tick();
    check("late rsp_valid", 64'(rsp_valid), 64'd0);
    check("late cmd_ready", 64'(cmd_ready), 64'd1);

    // Backpressure: response held for 10 cycles
    cmd_valid = 1'b1; cmd_addr = 32'h8; cmd_size = 4'd4; cmd_rd_wrn = 1'b1;
    tick();
    cmd_valid = 1'b0;
    lint_gnt = 1'b1; lint_r_valid = 1'b1; lint_r_rdata = 64'h1234_5678_9ABC_DEF0; lint_r_opc = 1'b0;
    tick();
    lint_gnt = 1'b0; lint_r_valid = 1'b0;
    held = 64'h9ABC_DEF0;
    cmd_valid = 1'b1; cmd_addr = 32'h0; cmd_size = 4'd1;
    for (int i = 0; i < 10; i++) begin
      check("bp rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp rdata", rsp_rdata, held);
      check("bp err", 64'(rsp_err), 64'd0);
      check("bp cmd_ready", 64'(cmd_ready), 64'd0);
      check("bp no_req", 64'(lint_req), 64'd0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp released", 64'(rsp_valid), 64'd0);
    check("bp ready_back", 64'(cmd_ready), 64'd1);

    // Reset while waiting for r_valid
    cmd_valid = 1'b1; cmd_addr = 32'h10; cmd_size = 4'd8; cmd_rd_wrn = 1'b1;
    tick();
    cmd_valid = 1'b0;
    lint_gnt = 1'b1;
    tick();
    lint_gnt = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst lint_req", 64'(lint_req), 64'd0);
    check("mid_rst rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    #1;
    check("mid_rst cmd_ready", 64'(cmd_ready), 64'd1);
    do_txn(tbl[0], "post_rst");

    // Randomized commands against the reference
    for (int n = 0; n < 40; n++) begin
      v.addr  = $urandom;
      if ($urandom_range(0, 4) != 0) v.size = 4'(1 << $urandom_range(0, 3));
      else v.size = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0 && v.size != 4'd0) v.addr = v.addr - (v.addr % 32'(v.size));
      v.wdata   = {$urandom, $urandom};
      v.rd      = 1'($urandom_range(0, 1));
      v.bus     = {$urandom, $urandom};
      v.opc     = ($urandom_range(0, 3) == 0);
      v.gnt_dly = $urandom_range(0, 3);
      v.rv_dly  = $urandom_range(0, 2);
      v = model(v);
      do_txn(v, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
